pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined MIPS CPU. It generalises the fixed decode-stage stall/forward logic to a configurable number of post-decode stages, register-address width and load-result stage. Each cycle it looks at the operands of the instruction in decode and returns stall and per-operand forwarding selects. It keeps its own shift register of in-flight writers (valid, write-enable, destination, is-load) and counts stall cycles for performance debug.

## Interface
- `ADDR_W`, default 5: register address width.
- `DEPTH`, default 3: number of tracked post-decode stages; stage 1 = EX, stage `DEPTH` = WB. Legal range is 2..8.
- `LOAD_STAGE`, default 2: first stage whose load result is forwardable (MEM). Legal range is 1..`DEPTH`.
- `CNT_W`, default 32: width of the stall counter.
- `SEL_W`, derived as $clog2(`DEPTH`+1); not overridable.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  global pipeline advance enable.
- `id_valid`  in  1  decode holds a real instruction.
- `id_rs_addr`, `id_rt_addr`  in  `ADDR_W`  source operand addresses.
- `id_rs_used`, `id_rt_used`  in  1  operand is actually read.
- `id_we`  in  1  decode instruction writes a register.
- `id_wr_addr`  in  `ADDR_W`  destination address.
- `id_is_load`  in  1  decode instruction is a load.
- `flush`  in  1  squash the decode instruction (taken redirect or trap).
- `stall`  out  1  hold IF/ID and inject a bubble.
- `fwd_rs_sel`, `fwd_rt_sel`  out  `SEL_W`  0 = register file, k = stage k result.
- `inflight`  out  `DEPTH`  valid bit per stage; bit k-1 = stage k.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled enabled cycles.

## Operation
- **Entry match.** Stage k matches operand X when all of the following hold: valid & we, addr == X addr, X addr != 0, X used, and `id_valid`.
- **Priority.** Only the youngest matching stage (smallest k) is considered, per operand.
- **Ready rule.** A matched entry is ready if it is not a load, or if k >= `LOAD_STAGE`.
  - Ready: fwd sel = k.
  - Not ready: operand hazard.
- `stall` = (rs hazard | rt hazard) & ~`flush`.
- While stalled, fwd sels are don't-care and are driven to 0.
- Register 0 never matches, stalls or forwards.
- **Update, on `clk` rising edge when `en` = 1:**
  - Stage 1 loads the decode entry if `id_valid` & ~`stall` & ~`flush`; otherwise it loads a bubble (valid = 0).
  - Stage k+1 loads stage k for every k.
  - The stage `DEPTH` entry retires. The register file write and read in the same cycle resolve to the new value, so a retired entry never needs tracking.
- **`en` = 0:** all state and `stall_cnt` hold. Outputs still follow the inputs combinationally.
- **`stall_cnt`:** increments on edges where `en` & `stall`. It saturates at all-ones and never wraps.
- **Simultaneous `flush` and hazard:** the flush wins; `stall` = 0 and a bubble enters stage 1.
- **Reset (`rst` = 0, at any time, asynchronously):**
  - Every entry is invalid and `stall_cnt` = 0.
  - As a result, `stall` = 0, both fwd sels = 0, and `inflight` = 0.
  - Reset asserted mid-stall drops the stall immediately.

## Timing
- `stall` and the fwd sels are purely combinational from the decode inputs and registered entries. They are valid in the same cycle for the decode-stage mux and the IF enable.
- Entry state has 1-cycle latency: an instruction accepted at edge n is in stage 1 after n and in stage k after edge n+k-1.
- Load-use penalty = `LOAD_STAGE` − 1 stall cycles when the consumer immediately follows the load (1 cycle at the defaults).
- `inflight` and `stall_cnt` are registered outputs.

## Configuration
- `PIPE_HAZARD_FWD_EN` defined: full forwarding as described above.
- `PIPE_HAZARD_FWD_EN` undefined:
  - Fwd sels are tied to 0.
  - Any match in stages 1..`DEPTH`-1 is a hazard, regardless of load status.
  - A match only in stage `DEPTH` is satisfied by the register-file same-cycle write and does not stall.
  - Without forwarding, a back-to-back ALU dependency costs `DEPTH`-1 stall cycles (2 at the defaults).

## Test plan
- **Reset mid-operation.** Fill all stages with valid writers, then pulse `rst` low between edges → `inflight` = 0, `stall` = 0, `stall_cnt` = 0 immediately.
- **ALU forwarding.** `addu r3` followed by `subu` reading rs = r3 → `fwd_rs_sel` = 1, `stall` = 0. One cycle later, with a non-dependent instruction in between → `fwd_rs_sel` = 2.
- **Load-use.** `lw r4` followed by `addu` reading rt = r4 → `stall` = 1 for exactly 1 cycle, stage 1 becomes a bubble, then `fwd_rt_sel` = 2 and `stall_cnt` = 1.
- **Priority and r0.** r5 is written at stages 1 and 2 → sel = 1. A reader of r0 behind a writer of r0 → sel = 0 and no stall.
- **Flush and hold.**
  - Assert `flush` during a load-use hazard → `stall` = 0 and `inflight` bit 0 = 0 after the edge.
  - Hold `en` = 0 for 3 cycles → `inflight` and `stall_cnt` unchanged.
- **Macro off, defaults.** Dependent ALU pair → `stall` for 2 cycles, fwd sels = 0. `stall_cnt` saturation is checked with `CNT_W` = 2: it reaches 3 and stays there.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard and forwarding controller tracking DEPTH post-decode writer stages.
// Optional full forwarding is enabled by defining PIPE_HAZARD_FWD_EN; otherwise only the register-file bypass is used.
module pipe_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_we,
    input  logic [ADDR_W-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [DEPTH-1:0]  inflight,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  we_r;
    logic [DEPTH-1:0]  load_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [DEPTH-1:0]  rs_match_s;
    logic [DEPTH-1:0]  rt_match_s;
    logic [SEL_W-1:0]  rs_hit_s;
    logic [SEL_W-1:0]  rt_hit_s;
    logic              rs_load_s;
    logic              rt_load_s;
    logic              rs_haz_s;
    logic              rt_haz_s;
    logic              stall_s;
    logic              accept_s;

    // Per-stage operand match; register 0 is hardwired and never matches.
    always_comb begin
        rs_match_s = '0;
        rt_match_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rs_match_s[k] = valid_r[k] & we_r[k] & (addr_r[k] == id_rs_addr) &
                            (id_rs_addr != '0) & id_rs_used & id_valid;
            rt_match_s[k] = valid_r[k] & we_r[k] & (addr_r[k] == id_rt_addr) &
                            (id_rt_addr != '0) & id_rt_used & id_valid;
        end
    end

    // Youngest match wins: scan oldest to youngest so smaller stages overwrite.
    always_comb begin
        rs_hit_s  = '0;
        rt_hit_s  = '0;
        rs_load_s = 1'b0;
        rt_load_s = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            rs_hit_s  = rs_match_s[k-1] ? SEL_W'(k)   : rs_hit_s;
            rs_load_s = rs_match_s[k-1] ? load_r[k-1] : rs_load_s;
            rt_hit_s  = rt_match_s[k-1] ? SEL_W'(k)   : rt_hit_s;
            rt_load_s = rt_match_s[k-1] ? load_r[k-1] : rt_load_s;
        end
    end

    // Hazard, stall and forwarding selects.
    always_comb begin
`ifdef PIPE_HAZARD_FWD_EN
        rs_haz_s = (rs_hit_s != '0) && rs_load_s && (rs_hit_s < SEL_W'(LOAD_STAGE));
        rt_haz_s = (rt_hit_s != '0) && rt_load_s && (rt_hit_s < SEL_W'(LOAD_STAGE));
`else
        // The last stage writes the register file in the same cycle it is read.
        rs_haz_s = (rs_hit_s != '0) && (rs_hit_s < SEL_W'(DEPTH));
        rt_haz_s = (rt_hit_s != '0) && (rt_hit_s < SEL_W'(DEPTH));
`endif
        stall_s  = (rs_haz_s | rt_haz_s) & ~flush;
        accept_s = id_valid & ~stall_s & ~flush;
`ifdef PIPE_HAZARD_FWD_EN
        fwd_rs_sel = (stall_s || rs_haz_s) ? '0 : rs_hit_s;
        fwd_rt_sel = (stall_s || rt_haz_s) ? '0 : rt_hit_s;
`else
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
`endif
    end

    // Writer shift register: decode entry or bubble enters stage 1, last stage retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            we_r    <= '0;
            load_r  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_r[k] <= '0;
            end
        end else if (en) begin
            valid_r <= {valid_r[DEPTH-2:0], accept_s};
            we_r    <= {we_r[DEPTH-2:0], accept_s & id_we};
            load_r  <= {load_r[DEPTH-2:0], accept_s & id_is_load};
            addr_r[0] <= id_wr_addr;
            for (int k = 1; k < DEPTH; k++) begin
                addr_r[k] <= addr_r[k-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Saturating count of enabled stall cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
        end else if (en && stall_s && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall     = stall_s;
    assign inflight  = valid_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit (DEPTH 3, LOAD_STAGE 2, CNT_W 2); expectations
// follow PIPE_HAZARD_FWD_EN so the bench matches either build.
module tb_pipe_hazard_unit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_we;
    logic [4:0] id_wr_addr;
    logic       id_is_load;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic [2:0] inflight;
    logic [1:0] stall_cnt;

    typedef struct {
        string      name;
        logic       stall;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [2:0] infl;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_unit #(.ADDR_W(5), .DEPTH(3), .LOAD_STAGE(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_we(id_we), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .inflight(inflight), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each sample strobe, pop and compare every pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (stall !== e.stall || fwd_rs_sel !== e.rs || fwd_rt_sel !== e.rt ||
                    inflight !== e.infl || stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got stall=%0b rs=%0d rt=%0d infl=%b cnt=%0d, expected stall=%0b rs=%0d rt=%0d infl=%b cnt=%0d",
                             e.name, stall, fwd_rs_sel, fwd_rt_sel, inflight, stall_cnt,
                             e.stall, e.rs, e.rt, e.infl, e.cnt);
                end
            end
        end
    end

    task automatic expect_out(input string name, input logic st, input logic [1:0] rs,
                              input logic [1:0] rt, input logic [2:0] infl, input logic [1:0] cnt);
        exp_t e;
        #1;
        e.name = name; e.stall = st; e.rs = rs; e.rt = rt; e.infl = infl; e.cnt = cnt;
        exp_q.push_back(e);
        ->sample_ev;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_used = 1'b0;
        id_rt_used = 1'b0; id_we = 1'b0; id_wr_addr = 5'd0; id_is_load = 1'b0; flush = 1'b0;
    endtask

    task automatic alu(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
        id_valid = 1'b1; id_rs_addr = rs; id_rt_addr = rt; id_rs_used = 1'b1;
        id_rt_used = 1'b1; id_we = 1'b1; id_wr_addr = wr; id_is_load = 1'b0; flush = 1'b0;
    endtask

    task automatic lw(input logic [4:0] wr, input logic [4:0] base);
        id_valid = 1'b1; id_rs_addr = base; id_rt_addr = 5'd0; id_rs_used = 1'b1;
        id_rt_used = 1'b0; id_we = 1'b1; id_wr_addr = wr; id_is_load = 1'b1; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        nop();
        expect_out("reset", 1'b0, 2'd0, 2'd0, 3'b000, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifdef PIPE_HAZARD_FWD_EN
        alu(5'd3, 5'd1, 5'd2);  expect_out("alu_first",  1'b0, 2'd0, 2'd0, 3'b000, 2'd0); tick();
        alu(5'd6, 5'd3, 5'd7);  expect_out("fwd_ex",     1'b0, 2'd1, 2'd0, 3'b001, 2'd0); tick();
        alu(5'd8, 5'd1, 5'd2);  expect_out("indep",      1'b0, 2'd0, 2'd0, 3'b011, 2'd0); tick();
        alu(5'd9, 5'd6, 5'd1);  expect_out("fwd_mem",    1'b0, 2'd2, 2'd0, 3'b111, 2'd0); tick();
        alu(5'd10, 5'd1, 5'd6); expect_out("fwd_wb_rt",  1'b0, 2'd0, 2'd3, 3'b111, 2'd0); tick();
        alu(5'd5, 5'd1, 5'd2);  expect_out("w_r5_a",     1'b0, 2'd0, 2'd0, 3'b111, 2'd0); tick();
        alu(5'd5, 5'd5, 5'd1);  expect_out("w_r5_b",     1'b0, 2'd1, 2'd0, 3'b111, 2'd0); tick();
        alu(5'd11, 5'd5, 5'd5); expect_out("priority",   1'b0, 2'd1, 2'd1, 3'b111, 2'd0); tick();
        lw(5'd4, 5'd1);         expect_out("lw_r4",      1'b0, 2'd0, 2'd0, 3'b111, 2'd0); tick();
        alu(5'd12, 5'd2, 5'd4); expect_out("load_use",   1'b1, 2'd0, 2'd0, 3'b111, 2'd0); tick();
        expect_out("load_fwd", 1'b0, 2'd0, 2'd2, 3'b110, 2'd1); tick();
        lw(5'd7, 5'd1);         expect_out("lw_r7",      1'b0, 2'd0, 2'd0, 3'b101, 2'd1); tick();
        alu(5'd13, 5'd7, 5'd2); flush = 1'b1;
        expect_out("flush_haz", 1'b0, 2'd0, 2'd0, 3'b011, 2'd1); tick();
        nop();                  expect_out("flush_bub",  1'b0, 2'd0, 2'd0, 3'b110, 2'd1); tick();
        alu(5'd0, 5'd1, 5'd2);  expect_out("w_r0",       1'b0, 2'd0, 2'd0, 3'b100, 2'd1); tick();
        alu(5'd14, 5'd0, 5'd0); expect_out("r0_read",    1'b0, 2'd0, 2'd0, 3'b001, 2'd1); tick();
        lw(5'd4, 5'd1);         expect_out("lw_hold",    1'b0, 2'd0, 2'd0, 3'b011, 2'd1); tick();
        alu(5'd17, 5'd4, 5'd2); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out("hold", 1'b1, 2'd0, 2'd0, 3'b111, 2'd1); tick();
        end
        en = 1'b1;
        expect_out("unhold", 1'b1, 2'd0, 2'd0, 3'b111, 2'd1); tick();
        expect_out("unhold_fwd", 1'b0, 2'd2, 2'd0, 3'b110, 2'd2); tick();
        lw(5'd4, 5'd1);         expect_out("lw_s1",      1'b0, 2'd0, 2'd0, 3'b101, 2'd2); tick();
        alu(5'd18, 5'd4, 5'd4); expect_out("use_s1",     1'b1, 2'd0, 2'd0, 3'b011, 2'd2); tick();
        expect_out("both_fwd", 1'b0, 2'd2, 2'd2, 3'b110, 2'd3); tick();
        lw(5'd4, 5'd1);         expect_out("lw_s2",      1'b0, 2'd0, 2'd0, 3'b101, 2'd3); tick();
        alu(5'd19, 5'd4, 5'd1); expect_out("use_s2",     1'b1, 2'd0, 2'd0, 3'b011, 2'd3); tick();
        expect_out("cnt_sat", 1'b0, 2'd2, 2'd0, 3'b110, 2'd3); tick();
`else
        alu(5'd3, 5'd1, 5'd2);  expect_out("alu_first",  1'b0, 2'd0, 2'd0, 3'b000, 2'd0); tick();
        alu(5'd6, 5'd3, 5'd7);  expect_out("dep_ex",     1'b1, 2'd0, 2'd0, 3'b001, 2'd0); tick();
        expect_out("dep_mem", 1'b1, 2'd0, 2'd0, 3'b010, 2'd1); tick();
        expect_out("dep_wb",  1'b0, 2'd0, 2'd0, 3'b100, 2'd2); tick();
        alu(5'd8, 5'd6, 5'd1); flush = 1'b1;
        expect_out("flush_haz", 1'b0, 2'd0, 2'd0, 3'b001, 2'd2); tick();
        nop();                  expect_out("flush_bub",  1'b0, 2'd0, 2'd0, 3'b010, 2'd2); tick();
        alu(5'd0, 5'd1, 5'd2);  expect_out("w_r0",       1'b0, 2'd0, 2'd0, 3'b100, 2'd2); tick();
        alu(5'd9, 5'd0, 5'd0);  expect_out("r0_read",    1'b0, 2'd0, 2'd0, 3'b001, 2'd2); tick();
        alu(5'd10, 5'd9, 5'd9); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out("hold", 1'b1, 2'd0, 2'd0, 3'b011, 2'd2); tick();
        end
        en = 1'b1;
        expect_out("unhold",  1'b1, 2'd0, 2'd0, 3'b011, 2'd2); tick();
        expect_out("cnt_sat", 1'b1, 2'd0, 2'd0, 3'b110, 2'd3); tick();
        expect_out("sat_hold", 1'b0, 2'd0, 2'd0, 3'b100, 2'd3); tick();
        lw(5'd4, 5'd1);         expect_out("lw_r4",      1'b0, 2'd0, 2'd0, 3'b001, 2'd3); tick();
        alu(5'd11, 5'd2, 5'd4); expect_out("load_use",   1'b1, 2'd0, 2'd0, 3'b011, 2'd3); tick();
`endif
        alu(5'd20, 5'd1, 5'd2); tick();
        alu(5'd21, 5'd1, 5'd2); tick();
        lw(5'd22, 5'd1);        tick();
        alu(5'd23, 5'd22, 5'd1);
        expect_out("full_stall", 1'b1, 2'd0, 2'd0, 3'b111, 2'd3);
        #2;
        rst = 1'b0;
        expect_out("mid_reset", 1'b0, 2'd0, 2'd0, 3'b000, 2'd0);
        #1;
        rst = 1'b1;
        tick();
        expect_out("post_reset", 1'b0, 2'd0, 2'd0, 3'b001, 2'd0);
        tick();
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
